// File: rtl/video_pkg.sv
// video_pkg: shared screen geometry, register map, FSM encoding and position clamp for the pointer block
package video_pkg;
  localparam int H_VISIBLE = 1280;
  localparam int V_VISIBLE = 720;
  localparam int POINTER_SIZE = 32;
  localparam logic [1:0] REG_POS_X = 2'd0;
  localparam logic [1:0] REG_POS_Y = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_HOTSPOT = 2'd3;
  localparam logic [0:0] ST_OPEN = 1'b0;
  localparam logic [0:0] ST_COMMIT = 1'b1;
  // Reads v as signed: negatives go to 0, anything past the visible edge goes to lim-1
  function automatic logic [15:0] clamp_pos(input logic [15:0] v, input int lim);
    return v[15] ? 16'd0 : (v > 16'(lim - 1)) ? 16'(lim - 1) : v;
  endfunction
endpackage

// File: rtl/video_pointer_axis.sv
// video_pointer_axis: one axis of the pointer sprite -- origin, wrapped offset and in-sprite test
module video_pointer_axis
  import video_pkg::*;
(
  input  logic [15:0] i_pos,
  input  logic [4:0]  i_hot,
  input  logic [15:0] i_coord,
  output logic [4:0]  o_off,
  output logic        o_in_range
);
  logic [15:0] w_origin;
  logic [15:0] w_off;
  assign w_origin = i_pos - {11'd0, i_hot};
  assign w_off = i_coord - w_origin;
  assign o_off = w_off[4:0];
  assign o_in_range = w_off < 16'(POINTER_SIZE);
endmodule

// File: rtl/video_pointer_ctrl.sv
// video_pointer_ctrl: double-buffered pointer registers committed on vsync; VIDEO_POINTER_CLAMP_EN clamps POS_X/POS_Y writes
module video_pointer_ctrl
  import video_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        vsync,
  input  logic        visible,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [4:0]  pointer_x,
  output logic [4:0]  pointer_y,
  output logic        pointer_active,
  output logic        pending
);
  logic [0:0]  r_state;
  logic        r_vsync_d, r_ready, r_pending;
  logic [15:0] r_sh_pos_x, r_sh_pos_y, r_pos_x, r_pos_y;
  logic [4:0]  r_sh_hot_x, r_sh_hot_y, r_hot_x, r_hot_y;
  logic        r_sh_en, r_en;
  logic        w_accept, w_to_commit, w_commit, w_in_x, w_in_y, w_hit;
  logic [15:0] w_wr_x, w_wr_y;
  logic [4:0]  w_off_x, w_off_y;
  assign w_accept = wr_valid & r_ready;
  assign w_to_commit = (r_state == ST_OPEN) & vsync & ~r_vsync_d;
  assign w_commit = r_state == ST_COMMIT;
  assign wr_ready = r_ready;
  assign pending = r_pending;
`ifdef VIDEO_POINTER_CLAMP_EN
  assign w_wr_x = clamp_pos(wr_data, H_VISIBLE);
  assign w_wr_y = clamp_pos(wr_data, V_VISIBLE);
`else
  assign w_wr_x = wr_data;
  assign w_wr_y = wr_data;
`endif
  // OPEN/COMMIT sequencing; wr_ready is registered so it stays low through reset and the commit cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_OPEN;
      r_vsync_d <= 1'b0;
      r_ready <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state <= w_to_commit ? ST_COMMIT : ST_OPEN;
      r_vsync_d <= vsync;
      r_ready <= ~w_to_commit;
      r_pending <= ~w_commit & (r_pending | w_accept);
    end
  end
  // Shadow registers take accepted writes, including one landing on the vsync edge cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_pos_x <= '0;
      r_sh_pos_y <= '0;
      r_sh_en <= 1'b0;
      r_sh_hot_x <= '0;
      r_sh_hot_y <= '0;
    end else if (w_accept) begin
      if (wr_addr == REG_POS_X) r_sh_pos_x <= w_wr_x;
      if (wr_addr == REG_POS_Y) r_sh_pos_y <= w_wr_y;
      if (wr_addr == REG_CTRL) r_sh_en <= wr_data[0];
      if (wr_addr == REG_HOTSPOT) begin
        r_sh_hot_x <= wr_data[4:0];
        r_sh_hot_y <= wr_data[12:8];
      end
    end
  end
  // Active registers change only at the end of the COMMIT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos_x <= '0;
      r_pos_y <= '0;
      r_en <= 1'b0;
      r_hot_x <= '0;
      r_hot_y <= '0;
    end else if (w_commit) begin
      r_pos_x <= r_sh_pos_x;
      r_pos_y <= r_sh_pos_y;
      r_en <= r_sh_en;
      r_hot_x <= r_sh_hot_x;
      r_hot_y <= r_sh_hot_y;
    end
  end
  video_pointer_axis u_axis_x (.i_pos(r_pos_x), .i_hot(r_hot_x), .i_coord(x), .o_off(w_off_x), .o_in_range(w_in_x));
  video_pointer_axis u_axis_y (.i_pos(r_pos_y), .i_hot(r_hot_y), .i_coord(y), .o_off(w_off_y), .o_in_range(w_in_y));
  assign w_hit = r_en & visible & w_in_x & w_in_y;
  // Pointer outputs lag x/y/visible by one clock; coordinates are zeroed off the sprite
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pointer_active <= 1'b0;
      pointer_x <= '0;
      pointer_y <= '0;
    end else begin
      pointer_active <= w_hit;
      pointer_x <= w_hit ? w_off_x : 5'd0;
      pointer_y <= w_hit ? w_off_y : 5'd0;
    end
  end
endmodule

// File: tb/tb_video_pointer_ctrl.sv
// tb_video_pointer_ctrl: randomized and directed checks of video_pointer_ctrl against a register-level model
module tb_video_pointer_ctrl;
  logic clk = 1'b0, reset = 1'b1, wr_valid = 1'b0, vsync = 1'b0, visible = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [15:0] wr_data = 16'd0, x = 16'd0, y = 16'd0;
  logic wr_ready, pointer_active, pending;
  logic [4:0] pointer_x, pointer_y;
  int checks = 0, errors = 0;
  logic [15:0] m_sh [4];
  logic [15:0] m_act [4];
  logic m_pending;

  video_pointer_ctrl dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .vsync(vsync), .visible(visible), .x(x), .y(y),
    .pointer_x(pointer_x), .pointer_y(pointer_y), .pointer_active(pointer_active), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_store(input logic [1:0] a, input logic [15:0] d);
`ifdef VIDEO_POINTER_CLAMP_EN
    int s, lim;
    s = $signed(d);
    lim = (a == 2'd0) ? 1279 : 719;
    if (a < 2'd2) return (s < 0) ? 16'd0 : (s > lim) ? 16'(lim) : d;
`endif
    return d;
  endfunction

  function automatic logic [10:0] m_expect(input logic [15:0] xx, input logic [15:0] yy, input logic vis);
    logic [15:0] ox, oy;
    ox = xx - (m_act[0] - {11'd0, m_act[3][4:0]});
    oy = yy - (m_act[1] - {11'd0, m_act[3][12:8]});
    if (m_act[2][0] && vis && ox < 16'd32 && oy < 16'd32) return {1'b1, ox[4:0], oy[4:0]};
    return 11'd0;
  endfunction

  task automatic m_reset;
    foreach (m_sh[i]) begin
      m_sh[i] = 16'd0;
      m_act[i] = 16'd0;
    end
    m_pending = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [15:0] xx, input logic [15:0] yy, input logic vis, input string nm);
    logic [10:0] e;
    e = m_expect(xx, yy, vis);
    x = xx;
    y = yy;
    visible = vis;
    tick();
    checks++;
    if ({pointer_active, pointer_x, pointer_y} !== e) begin
      errors++;
      $display("FAIL %s x=%0d y=%0d vis=%b: got act=%b px=%0d py=%0d, want act=%b px=%0d py=%0d",
               nm, xx, yy, vis, pointer_active, pointer_x, pointer_y, e[10], e[9:5], e[4:0]);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic ok, rdy;
    ok = 1'b0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 4 && !ok; i++) begin
      rdy = wr_ready;
      tick();
      ok = rdy;
    end
    wr_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_accept addr=%0d: wr_ready stayed 0, want a 1 within 4 cycles", a);
    end else begin
      m_sh[a] = m_store(a, d);
      m_pending = 1'b1;
    end
    checks++;
    if (pending !== m_pending) begin
      errors++;
      $display("FAIL pending_after_write addr=%0d: got %b want %b", a, pending, m_pending);
    end
  endtask

  task automatic do_commit;
    vsync = 1'b1;
    tick();
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL commit_ready_low: got %b want 0", wr_ready);
    end
    tick();
    foreach (m_act[i]) m_act[i] = m_sh[i];
    m_pending = 1'b0;
    checks++;
    if ({wr_ready, pending} !== 2'b10) begin
      errors++;
      $display("FAIL commit_done: got ready=%b pending=%b want ready=1 pending=0", wr_ready, pending);
    end
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({pointer_active, pointer_x, pointer_y, wr_ready, pending} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got act=%b px=%0d py=%0d ready=%b pending=%b want all 0",
               pointer_active, pointer_x, pointer_y, wr_ready, pending);
    end
    reset = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", wr_ready);
    end
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %b want 1", wr_ready);
    end
  endtask

  task automatic test_commit_basic;
    wr(2'd0, 16'd100);
    wr(2'd1, 16'd50);
    wr(2'd2, 16'd1);
    px(16'd100, 16'd50, 1'b1, "pre_commit");
    do_commit();
    px(16'd100, 16'd50, 1'b1, "basic_origin");
    px(16'd99, 16'd50, 1'b1, "basic_left");
    px(16'd131, 16'd81, 1'b1, "basic_corner");
    px(16'd132, 16'd50, 1'b1, "basic_right");
    px(16'd100, 16'd82, 1'b1, "basic_below");
    px(16'd110, 16'd60, 1'b0, "basic_invisible");
  endtask

  task automatic test_hotspot;
    wr(2'd3, 16'h0A05);
    do_commit();
    px(16'd95, 16'd40, 1'b1, "hot_origin");
    px(16'd94, 16'd40, 1'b1, "hot_left");
    px(16'd126, 16'd71, 1'b1, "hot_corner");
    px(16'd127, 16'd71, 1'b1, "hot_right");
    px(16'd95, 16'd39, 1'b1, "hot_above");
    px(16'd95, 16'd72, 1'b1, "hot_below");
  endtask

  task automatic test_edge_write;
    wr(2'd3, 16'd10);
    wr(2'd1, 16'd50);
    do_commit();
    wr_valid = 1'b1;
    wr_addr = 2'd0;
    wr_data = 16'd200;
    vsync = 1'b1;
    tick();
    m_sh[0] = m_store(2'd0, 16'd200);
    m_pending = 1'b1;
    wr_addr = 2'd1;
    wr_data = 16'd60;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL edge_commit_ready: got %b want 0", wr_ready);
    end
    tick();
    foreach (m_act[i]) m_act[i] = m_sh[i];
    m_pending = 1'b0;
    checks++;
    if ({wr_ready, pending} !== 2'b10) begin
      errors++;
      $display("FAIL edge_commit_done: got ready=%b pending=%b want ready=1 pending=0", wr_ready, pending);
    end
    tick();
    m_sh[1] = m_store(2'd1, 16'd60);
    m_pending = 1'b1;
    wr_valid = 1'b0;
    vsync = 1'b0;
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL held_write_pending: got %b want 1", pending);
    end
    px(16'd190, 16'd50, 1'b1, "edge_pos_x");
    px(16'd190, 16'd60, 1'b1, "held_y_uncommitted");
    do_commit();
    px(16'd190, 16'd60, 1'b1, "held_y_committed");
  endtask

  task automatic test_wrap;
    wr(2'd0, 16'd5);
    do_commit();
    px(16'd0, 16'd60, 1'b1, "wrap_x0");
    px(16'd26, 16'd60, 1'b1, "wrap_x26");
    px(16'd27, 16'd60, 1'b1, "wrap_x27");
    px(16'hFFFB, 16'd60, 1'b1, "wrap_origin");
    px(16'hFFFA, 16'd60, 1'b1, "wrap_before");
  endtask

  task automatic test_clamp;
    wr(2'd3, 16'd0);
    wr(2'd0, 16'h8000);
    wr(2'd1, 16'd0);
    do_commit();
    px(16'd0, 16'd0, 1'b1, "pos_8000_at_0");
    px(16'h8000, 16'd0, 1'b1, "pos_8000_at_8000");
    wr(2'd0, 16'd2000);
    wr(2'd1, 16'd900);
    do_commit();
    px(16'd1279, 16'd719, 1'b1, "pos_big_at_edge");
    px(16'd2000, 16'd900, 1'b1, "pos_big_at_raw");
  endtask

  task automatic test_random;
    logic [15:0] xx, yy;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 5))
        0: wr(2'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 100)));
        1: wr(2'd2, 16'($urandom));
        2: wr(2'd3, 16'($urandom));
        3: do_commit();
        default: begin
          xx = m_act[0] - {11'd0, m_act[3][4:0]} + 16'($urandom_range(0, 36)) - 16'd2;
          yy = m_act[1] - {11'd0, m_act[3][12:8]} + 16'($urandom_range(0, 36)) - 16'd2;
          px(xx, yy, $urandom_range(0, 4) != 0, "random_pixel");
        end
      endcase
    end
  endtask

  task automatic test_reset_commit;
    wr(2'd0, 16'd300);
    vsync = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    m_reset();
    checks++;
    if ({pointer_active, pointer_x, pointer_y, wr_ready, pending} !== 13'd0) begin
      errors++;
      $display("FAIL reset_in_commit: got act=%b px=%0d py=%0d ready=%b pending=%b want all 0",
               pointer_active, pointer_x, pointer_y, wr_ready, pending);
    end
    vsync = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_held_low: got %b want 0", wr_ready);
    end
    tick();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_commit_reset: got %b want 1", wr_ready);
    end
    wr(2'd2, 16'd1);
    do_commit();
    px(16'd0, 16'd0, 1'b1, "post_reset_origin");
    px(16'd300, 16'd0, 1'b1, "old_shadow_dropped");
  endtask

  initial begin
    m_reset();
    test_reset();
    test_commit_basic();
    test_hotspot();
    test_edge_write();
    test_wrap();
    test_clamp();
    test_random();
    test_reset_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_pointer_ctrl.md
VIDEO_POINTER_CTRL -- requirements
Module: video_pointer_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  pixel clock (vga_ck domain).
REQ-002 SHALL have port: reset  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-003 SHALL have ports: wr_valid in 1, wr_ready out 1, wr_addr in 2, wr_data in 16; register write channel.
REQ-004 SHALL have ports: vsync in 1, visible in 1, x in 16, y in 16; from video_timing, vsync active-high.
REQ-005 SHALL have ports: pointer_x out 5, pointer_y out 5, pointer_active out 1; sprite coordinates for video_composite.
REQ-006 SHALL have port: pending out 1; shadow registers hold uncommitted writes.

Function
REQ-007 SHALL decode registers: 0 POS_X, 1 POS_Y, 2 CTRL (bit0 enable), 3 HOTSPOT (hot_x = bits[4:0], hot_y = bits[12:8]); other bits ignored.
REQ-008 SHALL accept a write on any clk edge with wr_valid and wr_ready both high, into the shadow register selected by wr_addr.
REQ-009 SHALL implement FSM OPEN/COMMIT: OPEN has wr_ready=1; a vsync rising edge (vsync high, previous sample low) moves to COMMIT; COMMIT lasts exactly one cycle with wr_ready=0, copies all shadow registers to active registers, then returns to OPEN.
REQ-010 SHALL include, in the commit, a write accepted in the same cycle as the vsync edge.
REQ-011 SHALL hold wr_valid-asserted transfers during COMMIT; the master retries, no data lost.
REQ-012 SHALL set pending on any accepted write and clear it on the COMMIT cycle; a write in the edge cycle still clears on commit.
REQ-013 SHALL compute origin = pos - hot (16-bit, modulo 2^16) per axis, and off = coord - origin (16-bit, modulo).
REQ-014 SHALL assert pointer_active when active enable=1, visible=1, off_x[15:5]=0 and off_y[15:5]=0; pointer_x=off_x[4:0], pointer_y=off_y[4:0].
REQ-015 SHALL register pointer outputs: one clk latency from x/y/visible; video_composite compensates.
REQ-016 SHALL drive pointer_x/pointer_y to 0 whenever pointer_active=0.
REQ-017 SHALL render a partially off-screen pointer (origin negative or past right/bottom edge) by the modulo rule, no special casing.

Reset
REQ-018 SHALL, while reset high, force: shadow and active registers 0, enable 0, pending 0, wr_ready 0, FSM OPEN, pointer_active 0, pointer_x/y 0, vsync history 0.
REQ-019 SHALL raise wr_ready on the first clk edge after reset deasserts; reset mid-COMMIT abandons the commit.

Configuration
REQ-020 SHALL, with VIDEO_POINTER_CLAMP_EN defined, clamp POS_X writes to 0..H_VISIBLE-1 (1279) and POS_Y to 0..V_VISIBLE-1 (719), values read as signed 16-bit (negative -> 0).
REQ-021 SHALL, without VIDEO_POINTER_CLAMP_EN, store POS_X/POS_Y writes unmodified.

Structure
REQ-022 SHALL place H_VISIBLE, V_VISIBLE, POINTER_SIZE (32), register address constants and FSM state encoding in shared package video_pkg.
REQ-023 SHALL instantiate sub-module video_pointer_axis twice (X, Y): origin subtract, offset, in-range compare.

Verification
REQ-024 Write POS_X=100, POS_Y=50, CTRL=1 mid-frame -> pending=1, pointer_active stays 0 until vsync edge; next frame active for x 100..131, y 50..81, pointer_x=0 at x=100 one clk later.
REQ-025 HOTSPOT=0x0A05, POS=(100,50) -> active region x 95..126, y 40..71.
REQ-026 Write POS_X=200 in the vsync-edge cycle -> committed this frame; wr_valid held in COMMIT -> wr_ready=0 one cycle, write accepted next cycle, pending=1 again.
REQ-027 POS_X=5, hot_x=10 -> origin 0xFFFB; active x 0..26 with pointer_x 5..31.
REQ-028 Clamp build: POS_X=0x8000 -> 0, POS_X=2000 -> 1279; non-clamp build stores 0x8000 and 2000, pointer never active.
REQ-029 Assert reset during COMMIT -> all outputs 0, wr_ready 0, then 1 one edge after release; old shadow values not committed.
